// File: rtl/spare_scan_ctrl_if.sv
// Purpose: handshake and scan-chain signals between a requester, the spare-chain controller and the chain.
// Latency: wiring only, no storage.
// Backpressure: none; requests arriving while busy are dropped by the controller.
interface spare_scan_ctrl_if #(
  parameter int CHAIN_LEN = 10
);
  logic                 start;
  logic                 capture;
  logic [CHAIN_LEN-1:0] wr_data;
  logic                 so;
  logic                 si;
  logic                 scen;
  logic                 busy;
  logic                 done;
  logic [CHAIN_LEN-1:0] rd_data;
  logic                 rst_match;

  // Requester side, which also carries the chain's serial output back in.
  modport master (
    output start, capture, wr_data, so,
    input  si, scen, busy, done, rd_data, rst_match
  );

  // Controller side.
  modport slave (
    input  start, capture, wr_data, so,
    output si, scen, busy, done, rd_data, rst_match
  );
endinterface

// File: rtl/spare_scan_ctrl.sv
// Purpose: loads a word into the spare-cell scan chain and unloads its previous contents, with an optional capture cycle first.
// Latency: done arrives CHAIN_LEN+1 cycles after the start cycle, or CHAIN_LEN+2 cycles when capture is requested.
// Backpressure: start is accepted only in IDLE; requests seen while busy are dropped without queuing.
module spare_scan_ctrl #(
  parameter int                   CHAIN_LEN   = 10,
  parameter logic [CHAIN_LEN-1:0] RST_PATTERN = 10'b11_0000_0000
) (
  input  logic                  Clk,
  input  logic                  nReset,
  spare_scan_ctrl_if.slave      bus
);

  localparam int             CW   = $clog2(CHAIN_LEN);
  localparam logic [CW-1:0]  LAST = CW'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {IDLE, CAPT, SHIFT, FIN} state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [CHAIN_LEN-1:0] sh, sh_n;          // load word; MSB is the next bit to drive
  logic [CHAIN_LEN-1:0] unl, unl_n;        // bits collected so far in the current pass
  logic [CHAIN_LEN-1:0] rd_q, rd_n;
  logic                 si_q, si_n;
  logic                 scen_q, scen_n;
  logic                 busy_q, busy_n;
  logic                 done_q, done_n;
  logic                 match_q, match_n;

  // Registers: FSM state plus every output, so the chain sees a full stable cycle.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state   <= IDLE;
      cnt     <= '0;
      sh      <= '0;
      unl     <= '0;
      rd_q    <= '0;
      si_q    <= 1'b0;
      scen_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      sh      <= sh_n;
      unl     <= unl_n;
      rd_q    <= rd_n;
      si_q    <= si_n;
      scen_q  <= scen_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      match_q <= match_n;
    end
  end

  // Next state and next register values; scen/si are set one edge ahead of the cycle they describe.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    unl_n   = unl;
    rd_n    = rd_q;
    si_n    = 1'b0;
    scen_n  = 1'b0;
    busy_n  = busy_q;
    done_n  = 1'b0;
    match_n = match_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          sh_n   = bus.wr_data;
          cnt_n  = '0;
          busy_n = 1'b1;
          if (bus.capture) begin
            state_n = CAPT;
          end else begin
            state_n = SHIFT;
            scen_n  = 1'b1;
            si_n    = bus.wr_data[CHAIN_LEN-1];
          end
        end
      end
      CAPT: begin
        // scen stays low this cycle so the chain takes its functional inputs.
        state_n = SHIFT;
        cnt_n   = '0;
        scen_n  = 1'b1;
        si_n    = sh[CHAIN_LEN-1];
      end
      SHIFT: begin
        // so shows the last flop's old content before this edge shifts it out.
        unl_n = {unl[CHAIN_LEN-2:0], bus.so};
        sh_n  = sh << 1;
        if (cnt == LAST) begin
          state_n = FIN;
          rd_n    = unl_n;
          match_n = (unl_n == RST_PATTERN);
          done_n  = 1'b1;
        end else begin
          cnt_n  = cnt + 1'b1;
          scen_n = 1'b1;
          si_n   = sh[CHAIN_LEN-2];
        end
      end
      FIN: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.si        = si_q;
  assign bus.scen      = scen_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rd_data   = rd_q;
  assign bus.rst_match = match_q;

endmodule
